id_ex_skid: RTL and testbench

Parametrised, elastic ID/EX pipeline register for the pipelined core. It carries the decoded control bundle, operand data, register indices, immediate and PC from decode to execute. It adds four behaviours: a valid/ready handshake with a one-entry skid buffer, a flush, write-back bypass into held entries, and a saturating stall counter. It replaces the plain, always-load ID/EX register and sits between the decode stage and the execute/forwarding logic.

---
 rtl/id_ex_skid_pkg.sv | 32 +++
 rtl/id_ex_skid_if.sv | 57 +++++
 rtl/id_ex_skid_bypass.sv | 28 ++
 rtl/id_ex_skid.sv | 171 +++++++++++++++++
 tb/tb_id_ex_skid.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_skid_pkg.sv
// Shared types and default widths for the elastic ID/EX pipeline register.
// The payload struct here is the default-width view used by tools and benches.
package id_ex_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RA_W_DEF  = 5;
  localparam int WB_W_DEF  = 3;
  localparam int M_W_DEF   = 3;
  localparam int EX_W_DEF  = 2;
  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic [WB_W_DEF-1:0] wb;
    logic [M_W_DEF-1:0]  m;
    logic [EX_W_DEF-1:0] ex;
    logic [XLEN_DEF-1:0] rs1_data;
    logic [XLEN_DEF-1:0] rs2_data;
    logic [RA_W_DEF-1:0] rs1;
    logic [RA_W_DEF-1:0] rs2;
    logic [RA_W_DEF-1:0] rd;
    logic [XLEN_DEF-1:0] imm;
    logic [XLEN_DEF-1:0] pc;
  } id_ex_payload_t;

  // Occupancy of the output/skid pair: nothing, output only, or both.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } id_ex_state_e;

endpackage

// File: rtl/id_ex_skid_if.sv
// Decode-side and execute-side handshake plus payload of the ID/EX register.
// master = the surrounding pipeline (decode + execute), slave = the register.
interface id_ex_skid_if
  import id_ex_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF,
  parameter int WB_W = WB_W_DEF,
  parameter int M_W  = M_W_DEF,
  parameter int EX_W = EX_W_DEF
);

  logic            in_valid;
  logic            in_ready;
  logic [WB_W-1:0] in_wb;
  logic [M_W-1:0]  in_m;
  logic [EX_W-1:0] in_ex;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [RA_W-1:0] in_rs1;
  logic [RA_W-1:0] in_rs2;
  logic [RA_W-1:0] in_rd;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [WB_W-1:0] out_wb;
  logic [M_W-1:0]  out_m;
  logic [EX_W-1:0] out_ex;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [RA_W-1:0] out_rs1;
  logic [RA_W-1:0] out_rs2;
  logic [RA_W-1:0] out_rd;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;

  modport master (
    output in_valid, in_wb, in_m, in_ex, in_rs1_data, in_rs2_data,
           in_rs1, in_rs2, in_rd, in_imm, in_pc,
    input  in_ready,
    input  out_valid, out_wb, out_m, out_ex, out_rs1_data, out_rs2_data,
           out_rs1, out_rs2, out_rd, out_imm, out_pc,
    output out_ready
  );

  modport slave (
    input  in_valid, in_wb, in_m, in_ex, in_rs1_data, in_rs2_data,
           in_rs1, in_rs2, in_rd, in_imm, in_pc,
    output in_ready,
    output out_valid, out_wb, out_m, out_ex, out_rs1_data, out_rs2_data,
           out_rs1, out_rs2, out_rd, out_imm, out_pc,
    input  out_ready
  );

endinterface

// File: rtl/id_ex_skid_bypass.sv
// Combinational write-back patch of one payload: operand data whose source
// index matches a live register-file write (rd != x0) takes the written value.
module id_ex_bypass
  import id_ex_pkg::*;
#(
  parameter int  RA_W      = RA_W_DEF,
  parameter int  XLEN      = XLEN_DEF,
  parameter type payload_t = id_ex_payload_t
) (
  input  payload_t        pay_i,
  input  logic            wb_we_i,
  input  logic [RA_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output payload_t        pay_o
);

  logic wb_live;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if-chain can leave it unassigned and infer a latch.
  always_comb begin
    pay_o   = pay_i;
    wb_live = wb_we_i && (wb_rd_i != '0);
    if (wb_live && (pay_i.rs1 == wb_rd_i)) pay_o.rs1_data = wb_data_i;
    if (wb_live && (pay_i.rs2 == wb_rd_i)) pay_o.rs2_data = wb_data_i;
  end

endmodule

// File: rtl/id_ex_skid.sv
// Elastic ID/EX register: valid/ready with a one-entry skid, flush,
// write-back bypass into held and incoming entries, saturating stall counter.
module id_ex_skid
  import id_ex_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RA_W  = RA_W_DEF,
  parameter int WB_W  = WB_W_DEF,
  parameter int M_W   = M_W_DEF,
  parameter int EX_W  = EX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  id_ex_skid_if.slave      bus,
  input  logic             flush,
  input  logic             wb_we,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } payload_t;

  id_ex_state_e     state_q, state_d;
  payload_t         out_q, out_d;
  payload_t         skid_q, skid_d;
  payload_t         in_pay, in_fix, out_fix, skid_fix;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic out_valid, skid_valid, in_ready;
  logic accept, deliver;

  // Handshake flags depend on registered state only, so in_ready never
  // sees out_ready combinationally.
  assign out_valid  = (state_q != EMPTY);
  assign skid_valid = (state_q == TWO);
  assign in_ready   = !skid_valid;
  assign accept     = bus.in_valid && in_ready && !flush;
  assign deliver    = out_valid && bus.out_ready;

  always_comb begin
    in_pay          = '0;
    in_pay.wb       = bus.in_wb;
    in_pay.m        = bus.in_m;
    in_pay.ex       = bus.in_ex;
    in_pay.rs1_data = bus.in_rs1_data;
    in_pay.rs2_data = bus.in_rs2_data;
    in_pay.rs1      = bus.in_rs1;
    in_pay.rs2      = bus.in_rs2;
    in_pay.rd       = bus.in_rd;
    in_pay.imm      = bus.in_imm;
    in_pay.pc       = bus.in_pc;
  end

  id_ex_bypass #(.RA_W(RA_W), .XLEN(XLEN), .payload_t(payload_t)) u_byp_in (
    .pay_i     (in_pay),
    .wb_we_i   (wb_we),
    .wb_rd_i   (wb_rd),
    .wb_data_i (wb_data),
    .pay_o     (in_fix)
  );

  id_ex_bypass #(.RA_W(RA_W), .XLEN(XLEN), .payload_t(payload_t)) u_byp_out (
    .pay_i     (out_q),
    .wb_we_i   (wb_we),
    .wb_rd_i   (wb_rd),
    .wb_data_i (wb_data),
    .pay_o     (out_fix)
  );

  id_ex_bypass #(.RA_W(RA_W), .XLEN(XLEN), .payload_t(payload_t)) u_byp_skid (
    .pay_i     (skid_q),
    .wb_we_i   (wb_we),
    .wb_rd_i   (wb_rd),
    .wb_data_i (wb_data),
    .pay_o     (skid_fix)
  );

  // Invalid entries keep their old payload untouched so out_* stays quiet
  // while out_valid is low; only live entries take bypass patches.
  always_comb begin
    state_d = state_q;
    out_d   = out_valid  ? out_fix  : out_q;
    skid_d  = skid_valid ? skid_fix : skid_q;

    if (flush) begin
      state_d = EMPTY;
      out_d   = out_q;
      skid_d  = skid_q;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            out_d   = in_fix;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            out_d = in_fix;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = in_fix;
          end else if (deliver) begin
            state_d = EMPTY;
            out_d   = out_q;
          end
        end
        TWO: begin
          if (deliver) begin
            state_d = ONE;
            out_d   = skid_fix;
            skid_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !bus.out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: the payload registers are reset too, so out_* reads all-zero the
  // moment rst_n drops instead of leaking a stale instruction.
  // NOTE: state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_wb       = out_q.wb;
  assign bus.out_m        = out_q.m;
  assign bus.out_ex       = out_q.ex;
  assign bus.out_rs1_data = out_q.rs1_data;
  assign bus.out_rs2_data = out_q.rs2_data;
  assign bus.out_rs1      = out_q.rs1;
  assign bus.out_rs2      = out_q.rs2;
  assign bus.out_rd       = out_q.rd;
  assign bus.out_imm      = out_q.imm;
  assign bus.out_pc       = out_q.pc;
  assign stall_cnt        = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_skid.sv
// Bench for id_ex_skid: queue-based model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic with resets.
module tb_id_ex_skid;
  import id_ex_pkg::*;

  localparam int CNT_W = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                flush;
  logic                wb_we;
  logic [RA_W_DEF-1:0] wb_rd;
  logic [XLEN_DEF-1:0] wb_data;
  logic [CNT_W-1:0]    stall_cnt;

  id_ex_skid_if bus ();

  id_ex_skid #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .flush     (flush),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .stall_cnt (stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a FIFO of at most two entries ----
  id_ex_payload_t q[$];
  id_ex_payload_t shown;
  int unsigned    m_cnt;

  function automatic id_ex_payload_t patch(input id_ex_payload_t p, input logic we,
                                           input logic [RA_W_DEF-1:0] rd,
                                           input logic [XLEN_DEF-1:0] d);
    id_ex_payload_t r = p;
    if (we && rd != 0 && p.rs1 == rd) r.rs1_data = d;
    if (we && rd != 0 && p.rs2 == rd) r.rs2_data = d;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    id_ex_payload_t inc;
    bit dlv, acc;
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
      shown = '0;
    end else begin
      inc = '{wb: bus.in_wb, m: bus.in_m, ex: bus.in_ex,
              rs1_data: bus.in_rs1_data, rs2_data: bus.in_rs2_data,
              rs1: bus.in_rs1, rs2: bus.in_rs2, rd: bus.in_rd,
              imm: bus.in_imm, pc: bus.in_pc};
      dlv = (q.size() > 0) && bus.out_ready;
      acc = bus.in_valid && (q.size() < 2) && !flush;
      if (q.size() > 0) shown = q[0];
      if (q.size() > 0 && !bus.out_ready && m_cnt < CNT_MAX) m_cnt++;
      foreach (q[i]) q[i] = patch(q[i], wb_we, wb_rd, wb_data);
      inc = patch(inc, wb_we, wb_rd, wb_data);
      if (flush) q.delete();
      else begin
        if (dlv) void'(q.pop_front());
        if (acc) q.push_back(inc);
      end
    end
  end

  // Compare process: outputs must match the model on every falling edge.
  always @(negedge clk) begin : compare
    id_ex_payload_t got, exp;
    got = '{wb: bus.out_wb, m: bus.out_m, ex: bus.out_ex,
            rs1_data: bus.out_rs1_data, rs2_data: bus.out_rs2_data,
            rs1: bus.out_rs1, rs2: bus.out_rs2, rd: bus.out_rd,
            imm: bus.out_imm, pc: bus.out_pc};
    exp = (q.size() > 0) ? q[0] : shown;
    check("m_in_ready", bus.in_ready, (q.size() < 2));
    check("m_out_valid", bus.out_valid, (q.size() > 0));
    check("m_stall_cnt", stall_cnt, m_cnt);
    check("m_payload", got, exp);
  end

  // ---------------- stimulus helpers ------------------------------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc,
                       input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2);
    bus.in_valid    = v;
    bus.in_pc       = pc;
    bus.in_imm      = pc ^ 32'hA5A5_0000;
    bus.in_rs1      = rs1;
    bus.in_rs1_data = d1;
    bus.in_rs2      = rs2;
    bus.in_rs2_data = d2;
    bus.in_rd       = pc[6:2];
    bus.in_wb       = pc[4:2];
    bus.in_m        = pc[7:5];
    bus.in_ex       = pc[9:8];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    flush = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    bus.out_ready = 0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_stall", stall_cnt, 0);
    check("rst_out_pc", bus.out_pc, 0);
    rst_n = 1'b1;

    // Streaming at full rate.
    bus.out_ready = 1;
    drive(1, 32'h00, 1, 32'h1, 2, 32'h2); cycle();
    check("s1_pc0", bus.out_pc, 32'h00); check("s1_rdy0", bus.in_ready, 1);
    drive(1, 32'h04, 1, 32'h1, 2, 32'h2); cycle();
    check("s1_pc4", bus.out_pc, 32'h04); check("s1_rdy4", bus.in_ready, 1);
    drive(1, 32'h08, 1, 32'h1, 2, 32'h2); cycle();
    check("s1_pc8", bus.out_pc, 32'h08); check("s1_valid8", bus.out_valid, 1);
    bus.in_valid = 0; cycle();
    check("s1_drain_valid", bus.out_valid, 0);
    check("s1_drain_hold", bus.out_pc, 32'h08);

    // Back-pressure fills the skid entry.
    bus.out_ready = 0;
    drive(1, 32'h10, 1, 32'h1, 2, 32'h2); cycle();
    check("s2_pc10", bus.out_pc, 32'h10); check("s2_stall0", stall_cnt, 0);
    drive(1, 32'h14, 1, 32'h1, 2, 32'h2); cycle();
    check("s2_full", bus.in_ready, 0); check("s2_hold10", bus.out_pc, 32'h10);
    check("s2_stall1", stall_cnt, 1);
    bus.in_valid = 0; cycle();
    check("s2_stall2", stall_cnt, 2);
    bus.out_ready = 1; cycle();
    check("s2_pc14", bus.out_pc, 32'h14); check("s2_rdy", bus.in_ready, 1);
    cycle();
    check("s2_empty", bus.out_valid, 0);

    // Bypass into both held entries.
    bus.out_ready = 0;
    drive(1, 32'h20, 5, 32'h11, 6, 32'h66); cycle();
    drive(1, 32'h24, 5, 32'h22, 6, 32'h77); cycle();
    bus.in_valid = 0; wb_we = 1; wb_rd = 5; wb_data = 32'hDEAD_BEEF; cycle();
    wb_we = 0;
    check("s3_out_rs1", bus.out_rs1_data, 32'hDEAD_BEEF);
    check("s3_out_rs2", bus.out_rs2_data, 32'h66);
    bus.out_ready = 1; cycle();
    check("s3_skid_pc", bus.out_pc, 32'h24);
    check("s3_skid_rs1", bus.out_rs1_data, 32'hDEAD_BEEF);
    cycle();

    // x0 writes never bypass.
    bus.out_ready = 0;
    drive(1, 32'h30, 0, 32'h33, 6, 32'h66); cycle();
    drive(1, 32'h34, 0, 32'h44, 6, 32'h77); cycle();
    bus.in_valid = 0; wb_we = 1; wb_rd = 0; wb_data = 32'hDEAD_BEEF; cycle();
    wb_we = 0;
    check("s3_x0_out", bus.out_rs1_data, 32'h33);
    bus.out_ready = 1; cycle();
    check("s3_x0_skid", bus.out_rs1_data, 32'h44);
    cycle();

    // Flush while full, with a new instruction presented.
    bus.out_ready = 0;
    drive(1, 32'h40, 1, 32'h1, 2, 32'h2); cycle();
    drive(1, 32'h44, 1, 32'h1, 2, 32'h2); cycle();
    drive(1, 32'h99, 1, 32'h1, 2, 32'h2); flush = 1; cycle();
    check("s4_valid", bus.out_valid, 0); check("s4_rdy", bus.in_ready, 1);
    flush = 0; bus.in_valid = 0; cycle();
    check("s4_not_captured", bus.out_valid, 0);

    // Asynchronous reset mid-stall.
    drive(1, 32'h50, 3, 32'h5555, 4, 32'h6666); cycle();
    bus.in_valid = 0; cycle(); cycle();
    #2 rst_n = 1'b0;
    #1;
    check("s5_valid", bus.out_valid, 0);
    check("s5_stall", stall_cnt, 0);
    check("s5_pc", bus.out_pc, 0);
    check("s5_rs1d", bus.out_rs1_data, 0);
    check("s5_rdy", bus.in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Saturation of the 4-bit stall counter.
    drive(1, 32'h60, 1, 32'h1, 2, 32'h2); cycle();
    bus.in_valid = 0;
    repeat (14) cycle();
    check("s6_stall14", stall_cnt, 14);
    repeat (6) cycle();
    check("s6_sat", stall_cnt, 15);
    bus.out_ready = 1; cycle();
    check("s6_sat_hold", stall_cnt, 15);

    // Randomized traffic; small index range makes bypass hits common.
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 125) begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      drive($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 3)), $urandom,
            5'($urandom_range(0, 3)), $urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 19) == 0);
      wb_we   = $urandom_range(0, 1);
      wb_rd   = 5'($urandom_range(0, 3));
      wb_data = $urandom;
      cycle();
    end

    bus.in_valid = 0; flush = 0; wb_we = 0;
    cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
